// File: rtl/codec_dac_bus_parser.sv
// codec_dac_bus_parser
// Recovers left/right DAC sample words by sniffing the codec serial bus
// (BCLK, LRCK, DAT) in the system clock domain, and flags truncated frames.
//
// Parameters:
//   DATA_WIDTH  - sample word width (8..32)
//   MODE        - 0: left-justified (LRCK=1 left, MSB on the LRCK-edge bit)
//                 1: I2S (LRCK=0 left, MSB one BCLK after the LRCK edge)
//   SYNC_STAGES - synchronizer depth for the bus pins (>= 2)
//
// Ports:
//   CLK, RESET              - system clock, synchronous active-high reset
//   BCLK, LRCK, DAT         - codec bus pins (asynchronous to CLK)
//   LCHAN_DATA, RCHAN_DATA  - last complete left/right word
//   LCHAN_VALID, RCHAN_VALID- one-CLK pulse when the matching word updates
//   FRAME_ERR               - one-CLK pulse on a truncated channel frame
//   SYNCED                  - high once the first LRCK transition is seen
module codec_dac_bus_parser #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned MODE        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  BCLK,
    input  logic                  LRCK,
    input  logic                  DAT,
    output logic [DATA_WIDTH-1:0] LCHAN_DATA,
    output logic [DATA_WIDTH-1:0] RCHAN_DATA,
    output logic                  LCHAN_VALID,
    output logic                  RCHAN_VALID,
    output logic                  FRAME_ERR,
    output logic                  SYNCED
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        SKIP,
        SHIFT,
        HOLD
    } state_t;

    // Pin synchronizers and bit strobe generation
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bclk_prev;
    logic                   bit_stb;
    logic                   lrck_smp;
    logic                   dat_smp;

    // LRCK/DAT are registered alongside the strobe so they stay aligned with it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            bit_stb   <= 1'b0;
            lrck_smp  <= 1'b0;
            dat_smp   <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], LRCK};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], DAT};
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
            bit_stb   <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
            lrck_smp  <= lrck_sync[SYNC_STAGES-1];
            dat_smp   <= dat_sync[SYNC_STAGES-1];
        end
    end

    // Frame parser state
    state_t                state,      state_n;
    logic                  lrck_last,  lrck_last_n;
    logic                  have_last,  have_last_n;
    logic                  chan_left,  chan_left_n;
    logic [DATA_WIDTH-1:0] shreg,      shreg_n;
    logic [CNT_W-1:0]      cnt,        cnt_n;
    logic [DATA_WIDTH-1:0] ldata_n,    rdata_n;
    logic                  lvalid_n,   rvalid_n;
    logic                  ferr_n,     synced_n;

    logic                  lr_edge_c;
    logic                  new_left_c;
    logic [DATA_WIDTH-1:0] shift_c;
    logic [CNT_W-1:0]      cnt_inc_c;

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= WAIT_SYNC;
            lrck_last   <= 1'b0;
            have_last   <= 1'b0;
            chan_left   <= 1'b0;
            shreg       <= '0;
            cnt         <= '0;
            LCHAN_DATA  <= '0;
            RCHAN_DATA  <= '0;
            LCHAN_VALID <= 1'b0;
            RCHAN_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
            SYNCED      <= 1'b0;
        end else begin
            state       <= state_n;
            lrck_last   <= lrck_last_n;
            have_last   <= have_last_n;
            chan_left   <= chan_left_n;
            shreg       <= shreg_n;
            cnt         <= cnt_n;
            LCHAN_DATA  <= ldata_n;
            RCHAN_DATA  <= rdata_n;
            LCHAN_VALID <= lvalid_n;
            RCHAN_VALID <= rvalid_n;
            FRAME_ERR   <= ferr_n;
            SYNCED      <= synced_n;
        end
    end

    // Next-state and output logic
    always_comb begin
        // An LRCK edge needs a prior strobe to compare against; the first strobe
        // after reset only records LRCK so a reset mid-frame cannot fake an edge.
        lr_edge_c   = bit_stb & have_last & (lrck_smp != lrck_last);
        new_left_c  = (MODE == 0) ? lrck_smp : ~lrck_smp;
        shift_c     = {shreg[DATA_WIDTH-2:0], dat_smp};
        cnt_inc_c   = cnt + CNT_W'(1);

        state_n     = state;
        lrck_last_n = bit_stb ? lrck_smp : lrck_last;
        have_last_n = have_last | bit_stb;
        chan_left_n = chan_left;
        shreg_n     = shreg;
        cnt_n       = cnt;
        ldata_n     = LCHAN_DATA;
        rdata_n     = RCHAN_DATA;
        lvalid_n    = 1'b0;
        rvalid_n    = 1'b0;
        ferr_n      = 1'b0;
        synced_n    = SYNCED;

        if (lr_edge_c) begin
            // Partial word in flight is dropped; outputs keep the old word
            if (state == SHIFT || state == SKIP) begin
                ferr_n = 1'b1;
            end
            synced_n    = 1'b1;
            chan_left_n = new_left_c;
            if (MODE == 0) begin
                state_n = SHIFT;
                shreg_n = shift_c;
                cnt_n   = CNT_W'(1);
            end else begin
                state_n = SKIP;
                cnt_n   = '0;
            end
        end else if (bit_stb) begin
            case (state)
                // The LRCK-edge bit was the discarded slot; this bit is the MSB
                SKIP: begin
                    state_n = SHIFT;
                    shreg_n = shift_c;
                    cnt_n   = CNT_W'(1);
                end
                SHIFT: begin
                    shreg_n = shift_c;
                    cnt_n   = cnt_inc_c;
                    if (cnt_inc_c == CNT_W'(DATA_WIDTH)) begin
                        state_n = HOLD;
                        if (chan_left) begin
                            ldata_n  = shift_c;
                            lvalid_n = 1'b1;
                        end else begin
                            rdata_n  = shift_c;
                            rvalid_n = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_dac_bus_parser.sv
// Directed bench for codec_dac_bus_parser: one left-justified 16-bit instance
// and one I2S 24-bit instance, driven bit by bit with hand-computed words.
module tb_codec_dac_bus_parser;

    logic        clk;
    logic        rst;
    logic        bclk_a, lrck_a, dat_a;
    logic        bclk_b, lrck_b, dat_b;
    logic [15:0] ldata_a, rdata_a;
    logic        lvalid_a, rvalid_a, ferr_a, synced_a;
    logic [23:0] ldata_b, rdata_b;
    logic        lvalid_b, rvalid_b, ferr_b, synced_b;

    int cyc;
    int lv_a_n, rv_a_n, fe_a_n, both_a_n, lv_a_cyc, rv_a_cyc, fe_a_cyc;
    int lv_b_n, rv_b_n, fe_b_n, both_b_n, lv_b_cyc, rv_b_cyc;
    int total, bad;
    int rise_cyc, first_rise, lsb_rise;

    codec_dac_bus_parser #(.DATA_WIDTH(16), .MODE(0), .SYNC_STAGES(2)) dut_a (
        .CLK(clk), .RESET(rst), .BCLK(bclk_a), .LRCK(lrck_a), .DAT(dat_a),
        .LCHAN_DATA(ldata_a), .RCHAN_DATA(rdata_a),
        .LCHAN_VALID(lvalid_a), .RCHAN_VALID(rvalid_a),
        .FRAME_ERR(ferr_a), .SYNCED(synced_a)
    );

    codec_dac_bus_parser #(.DATA_WIDTH(24), .MODE(1), .SYNC_STAGES(2)) dut_b (
        .CLK(clk), .RESET(rst), .BCLK(bclk_b), .LRCK(lrck_b), .DAT(dat_b),
        .LCHAN_DATA(ldata_b), .RCHAN_DATA(rdata_b),
        .LCHAN_VALID(lvalid_b), .RCHAN_VALID(rvalid_b),
        .FRAME_ERR(ferr_b), .SYNCED(synced_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitors: count pulses and remember the cycle of the latest one
    always @(negedge clk) begin
        if (lvalid_a) begin lv_a_n <= lv_a_n + 1; lv_a_cyc <= cyc; end
        if (rvalid_a) begin rv_a_n <= rv_a_n + 1; rv_a_cyc <= cyc; end
        if (ferr_a)   begin fe_a_n <= fe_a_n + 1; fe_a_cyc <= cyc; end
        if (lvalid_a && rvalid_a) both_a_n <= both_a_n + 1;
        if (lvalid_b) begin lv_b_n <= lv_b_n + 1; lv_b_cyc <= cyc; end
        if (rvalid_b) begin rv_b_n <= rv_b_n + 1; rv_b_cyc <= cyc; end
        if (ferr_b)   fe_b_n <= fe_b_n + 1;
        if (lvalid_b && rvalid_b) both_b_n <= both_b_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One BCLK period: LRCK/DAT change with the falling edge
    task automatic send_bit(input int bus, input logic lr, input logic d, input int ph);
        if (bus == 0) begin bclk_a = 1'b0; lrck_a = lr; dat_a = d; end
        else          begin bclk_b = 1'b0; lrck_b = lr; dat_b = d; end
        repeat (ph) @(negedge clk);
        if (bus == 0) bclk_a = 1'b1;
        else          bclk_b = 1'b1;
        rise_cyc = cyc;
        repeat (ph) @(negedge clk);
    endtask

    // Channel frame: lead filler bits, nbits of word MSB first, then filler ones
    task automatic send_frame(input int bus, input logic lr, input logic [31:0] word,
                              input int dw, input int nbits, input int nbclk,
                              input int lead, input int ph);
        for (int i = 0; i < nbclk; i++) begin
            int   k;
            logic d;
            k = i - lead;
            d = 1'b1;
            if (k >= 0 && k < nbits) d = word[dw-1-k];
            send_bit(bus, lr, d, ph);
            if (i == 0) first_rise = rise_cyc;
            if (k == dw - 1) lsb_rise = rise_cyc;
        end
    endtask

    initial begin
        int base_l, base_r, base_f;
        int l_lsb, r_lsb, f_start;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bclk_a = 1'b0; lrck_a = 1'b0; dat_a = 1'b0;
        bclk_b = 1'b0; lrck_b = 1'b0; dat_b = 1'b0;
        idle(3);
        check("rst_ldata_a",  32'(ldata_a),  32'h0);
        check("rst_rdata_a",  32'(rdata_a),  32'h0);
        check("rst_lvalid_a", 32'(lvalid_a), 32'h0);
        check("rst_ferr_a",   32'(ferr_a),   32'h0);
        check("rst_synced_a", 32'(synced_a), 32'h0);
        check("rst_synced_b", 32'(synced_b), 32'h0);
        rst = 1'b0;
        idle(2);

        // I2S, 24-bit word in 32-BCLK channels with 7 trailing bits
        for (int i = 0; i < 3; i++) send_bit(1, 1'b1, 1'b0, 4);
        send_frame(1, 1'b0, 32'h123456, 24, 24, 32, 1, 4);
        l_lsb = lsb_rise;
        send_frame(1, 1'b1, 32'hFEDCBA, 24, 24, 32, 1, 4);
        idle(8);
        check("i2s_ldata",   32'(ldata_b), 32'h123456);
        check("i2s_rdata",   32'(rdata_b), 32'hFEDCBA);
        check("i2s_lvalid_n", 32'(lv_b_n), 32'd1);
        check("i2s_rvalid_n", 32'(rv_b_n), 32'd1);
        check("i2s_ferr_n",   32'(fe_b_n), 32'd0);
        check("i2s_l_latency", 32'(lv_b_cyc - l_lsb), 32'd4);
        check("i2s_synced",   32'(synced_b), 32'h1);
        check("i2s_overlap",  32'(both_b_n), 32'd0);

        // Left-justified: start mid-right-frame, then L=8001, R=7FFF
        for (int i = 0; i < 9; i++) send_bit(0, 1'b0, 1'b1, 4);
        idle(6);
        check("mid_synced",  32'(synced_a), 32'h0);
        check("mid_lvalid_n", 32'(lv_a_n), 32'd0);
        check("mid_rvalid_n", 32'(rv_a_n), 32'd0);
        send_frame(0, 1'b1, 32'h8001, 16, 16, 16, 0, 4);
        l_lsb = lsb_rise;
        send_frame(0, 1'b0, 32'h7FFF, 16, 16, 16, 0, 4);
        r_lsb = lsb_rise;
        idle(8);
        check("lj_ldata",     32'(ldata_a), 32'h8001);
        check("lj_rdata",     32'(rdata_a), 32'h7FFF);
        check("lj_lvalid_n",  32'(lv_a_n), 32'd1);
        check("lj_rvalid_n",  32'(rv_a_n), 32'd1);
        check("lj_l_latency", 32'(lv_a_cyc - l_lsb), 32'd4);
        check("lj_r_latency", 32'(rv_a_cyc - r_lsb), 32'd4);
        check("lj_first_is_left", 32'(lv_a_cyc < rv_a_cyc), 32'd1);
        check("lj_synced",    32'(synced_a), 32'h1);
        check("lj_ferr_n",    32'(fe_a_n), 32'd0);

        // Truncated left frame between good frames
        send_frame(0, 1'b1, 32'hAAAA, 16, 16, 16, 0, 4);
        send_frame(0, 1'b0, 32'h0F0F, 16, 16, 16, 0, 4);
        idle(8);
        check("tr_ldata_pre", 32'(ldata_a), 32'hAAAA);
        check("tr_rdata_pre", 32'(rdata_a), 32'h0F0F);
        base_l = lv_a_n; base_r = rv_a_n; base_f = fe_a_n;
        send_frame(0, 1'b1, 32'h1234, 16, 10, 10, 0, 4);
        send_frame(0, 1'b0, 32'h5555, 16, 16, 16, 0, 4);
        f_start = first_rise;
        idle(8);
        check("tr_ferr_n",     32'(fe_a_n - base_f), 32'd1);
        check("tr_ferr_latency", 32'(fe_a_cyc - f_start), 32'd4);
        check("tr_lvalid_n",   32'(lv_a_n - base_l), 32'd0);
        check("tr_ldata_kept", 32'(ldata_a), 32'hAAAA);
        check("tr_rdata",      32'(rdata_a), 32'h5555);
        check("tr_rvalid_n",   32'(rv_a_n - base_r), 32'd1);

        // Reset 8 bits into a left frame
        base_l = lv_a_n; base_r = rv_a_n; base_f = fe_a_n;
        send_frame(0, 1'b1, 32'hF0F0, 16, 8, 8, 0, 4);
        rst = 1'b1;
        idle(1);
        check("mr_ldata",  32'(ldata_a),  32'h0);
        check("mr_rdata",  32'(rdata_a),  32'h0);
        check("mr_synced", 32'(synced_a), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(0, 1'b1, 1'b1, 4);
        idle(6);
        check("mr_wait_synced", 32'(synced_a), 32'h0);
        check("mr_wait_pulses", 32'((lv_a_n - base_l) + (rv_a_n - base_r) + (fe_a_n - base_f)), 32'd0);
        send_frame(0, 1'b0, 32'h3C3C, 16, 16, 16, 0, 4);
        send_frame(0, 1'b1, 32'h6969, 16, 16, 16, 0, 4);
        idle(8);
        check("mr_rdata_after", 32'(rdata_a), 32'h3C3C);
        check("mr_ldata_after", 32'(ldata_a), 32'h6969);
        check("mr_synced_after", 32'(synced_a), 32'h1);
        check("mr_ferr_n",      32'(fe_a_n - base_f), 32'd0);

        // Minimum legal BCLK phases (3 CLKs high/low)
        base_l = lv_a_n; base_r = rv_a_n; base_f = fe_a_n;
        send_frame(0, 1'b0, 32'hC3A5, 16, 16, 16, 0, 3);
        send_frame(0, 1'b1, 32'hC3A5, 16, 16, 16, 0, 3);
        idle(8);
        check("fast_rdata",    32'(rdata_a), 32'hC3A5);
        check("fast_ldata",    32'(ldata_a), 32'hC3A5);
        check("fast_rvalid_n", 32'(rv_a_n - base_r), 32'd1);
        check("fast_lvalid_n", 32'(lv_a_n - base_l), 32'd1);
        check("fast_ferr_n",   32'(fe_a_n - base_f), 32'd0);
        check("lj_overlap",    32'(both_a_n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
